ahb_sram_slave: RTL

//  Parametrised AHB-Lite memory slave. Successor to the first AHB slave, adding:
//   - byte-lane writes and hsize-aware accesses;
//   - a programmable wait-state count;
//   - the two-cycle ERROR response;
//   - write-to-read forwarding.

---
 rtl/ahb_pkg.sv | 46 ++++
 rtl/ahb_sram_slave_if.sv | 31 +++
 rtl/ahb_sram_bank.sv | 32 +++
 rtl/ahb_sram_slave.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite protocol constants, slave FSM states and byte-lane decode.
// Shared by the SRAM slave, its memory bank and the testbench.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Lane mask for a bus up to 64 bits; callers keep the low DATA_WIDTH/8 bits.
    function automatic logic [7:0] be_decode(
        input logic [2:0] addr_lsb,
        input logic [2:0] hsize
    );
        logic [15:0] m;
        m = (16'd1 << (5'd1 << hsize)) - 16'd1;
        m = m << addr_lsb;
        return m[7:0];
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave port bundle.
// The master side also drives hready, the muxed bus-ready.
interface ahb_sram_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize,
        output hburst, hprot, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize,
        input  hburst, hprot, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_bank.sv
// Word-organised SRAM array with byte-lane writes and a registered read port.
// Read data holds until the next read enable.
module ahb_sram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    localparam int NB = DATA_WIDTH / 8,
    localparam int IW = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [NB-1:0]         be,
    input  logic [IW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [IW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: wait states, two-cycle ERROR, byte lanes and
// forwarding of a write completing on the same edge a read is sampled.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic            hclk,
    input logic            hreset,
    ahb_sram_slave_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(NB);
    localparam logic [2:0] MAX_SIZE = 3'(LSB);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IW-1:0]         idx_q;
    logic [2:0]            lane_q;
    logic [2:0]            size_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] fwd_mask_q, fwd_data_q;
    logic [DATA_WIDTH-1:0] bank_rdata, wmask;
    logic [7:0]            be8;
    logic [NB-1:0]         be;
    logic                  readyout, accept, addr_err;
    logic                  we, rd_hit, rd_phase;
    logic                  unused;

    assign readyout = !(state_q inside {ST_WAIT, ST_ERR1});
    assign accept   = bus.hsel & bus.hready & bus.htrans[1] & readyout;

    assign addr_err = (64'(bus.haddr) >= MEM_BYTES)
                    | (bus.hsize > MAX_SIZE)
                    | (|(bus.haddr[2:0] & ((3'd1 << bus.hsize) - 3'd1)));

    assign be8 = be_decode(lane_q, size_q);
    assign be  = be8[NB-1:0];
    always_comb begin
        wmask = '0;
        for (int b = 0; b < NB; b++) begin
            wmask[b*8 +: 8] = {8{be[b]}};
        end
    end

    // A write only lands at the edge closing its LAST cycle.
    assign we = (state_q == ST_LAST) & wr_q & ~hreset;
    assign rd_hit = we & ~bus.hwrite & (bus.haddr[LSB +: IW] == idx_q);

    ahb_sram_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_bank (
        .clk   (hclk),
        .we    (we),
        .be    (be),
        .waddr (idx_q),
        .wdata (bus.hwdata),
        .re    (accept & ~addr_err & ~bus.hwrite),
        .raddr (bus.haddr[LSB +: IW]),
        .rdata (bank_rdata)
    );

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            wr_q       <= 1'b0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q      <= bus.haddr[LSB +: IW];
                lane_q     <= bus.haddr[2:0] & 3'(NB - 1);
                size_q     <= bus.hsize;
                wr_q       <= bus.hwrite;
                fwd_mask_q <= rd_hit ? wmask : '0;
                fwd_data_q <= bus.hwdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_LAST;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WS == 4'd0) begin
                        state_d = ST_LAST;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS;
                    end
                end
            end
        endcase
    end

    assign rd_phase = ~wr_q & (state_q inside {ST_WAIT, ST_LAST});

    assign bus.hreadyout = readyout;
    assign bus.hresp  = (state_q inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.hrdata = rd_phase
                      ? ((bank_rdata & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q))
                      : '0;

    assign unused = ^{bus.hburst, bus.hprot, bus.htrans[0], be8};
endmodule
